// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// icache fill path and the dcache fill/writeback path.
module mem_arbiter #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_valid,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_valid,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;

  state_t                r_state;
  owner_t                r_owner;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last_dc;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [LINE_WIDTH-1:0] r_mem_wdata;
  logic                  r_ic_valid;
  logic                  r_dc_valid;
  logic [LINE_WIDTH-1:0] r_ic_rdata;
  logic [LINE_WIDTH-1:0] r_dc_rdata;

  logic w_ic_elig;
  logic w_dc_elig;
  logic w_grant_ic;
  logic w_grant_dc;

  // A requester is still holding req in its own valid cycle; it must not be regranted then.
  assign w_ic_elig  = ic_req & ~r_ic_valid;
  assign w_dc_elig  = dc_req & ~r_dc_valid;
  assign w_grant_dc = w_dc_elig & (~w_ic_elig | ~r_last_dc);
  assign w_grant_ic = w_ic_elig & ~w_grant_dc;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_cnt       <= '0;
      r_last_dc   <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_valid  <= 1'b0;
      r_dc_valid  <= 1'b0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
    end else begin
      // NOTE: valids default low each cycle, so any set below is a single-cycle pulse.
      r_ic_valid <= 1'b0;
      r_dc_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_ic) begin
            r_state     <= S_BUSY;
            r_owner     <= OWN_IC;
            r_last_dc   <= 1'b0;
            r_cnt       <= CNT_LOAD;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ic_addr;
            r_mem_wdata <= '0;
          end else if (w_grant_dc) begin
            r_state     <= S_BUSY;
            r_owner     <= OWN_DC;
            r_last_dc   <= 1'b1;
            r_cnt       <= CNT_LOAD;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dc_we;
            r_mem_addr  <= dc_addr;
            r_mem_wdata <= dc_wdata;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            if (!r_mem_we) begin
              if (r_owner == OWN_IC) r_ic_rdata <= mem_rdata;
              if (r_owner == OWN_DC) r_dc_rdata <= mem_rdata;
            end
            r_ic_valid  <= (r_owner == OWN_IC);
            r_dc_valid  <= (r_owner == OWN_DC);
            r_state     <= S_IDLE;
            r_owner     <= OWN_NONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ic_valid  = r_ic_valid;
  assign ic_rdata  = r_ic_rdata;
  assign dc_valid  = r_dc_valid;
  assign dc_rdata  = r_dc_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state == S_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline reference model with a TB-owned
// memory, directed scenarios, a randomized phase and a MEM_LATENCY=1 instance.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;
  localparam int L  = 5;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } dc_job_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0, mem_rdata = '0;
  logic          ic_valid, dc_valid, mem_req, mem_we, busy;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          s_ic_req = 1'b0, s_dc_req = 1'b0, s_dc_we = 1'b0;
  logic [AW-1:0] s_ic_addr = '0, s_dc_addr = '0;
  logic [LW-1:0] s_dc_wdata = '0, s_mem_rdata = '0;
  logic          s_ic_valid, s_dc_valid, s_mem_req, s_mem_we, s_busy;
  logic [LW-1:0] s_ic_rdata, s_dc_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MEM_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_valid(dc_valid), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .ic_req(s_ic_req), .ic_addr(s_ic_addr), .ic_valid(s_ic_valid), .ic_rdata(s_ic_rdata),
    .dc_req(s_dc_req), .dc_we(s_dc_we), .dc_addr(s_dc_addr), .dc_wdata(s_dc_wdata),
    .dc_valid(s_dc_valid), .dc_rdata(s_dc_rdata),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .busy(s_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one transaction timeline (grant cycle m_gs) plus requester queues.
  int            c = 0;
  bit            m_act = 1'b0;
  int            m_gs = 0;
  bit            m_own_dc = 1'b0;
  bit            m_last_dc = 1'b1;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] m_cap = '0, m_ic_rd = '0, m_dc_rd = '0;
  logic [LW-1:0] mem_arr [logic [AW-1:0]];
  logic [AW-1:0] ic_q [$];
  dc_job_t       dc_q [$];
  bit            ic_done = 1'b0, dc_done = 1'b0, rand_raise = 1'b0;

  int ic_vcyc = 0, dc_vcyc = 0, n_req_cyc = 0, n_we_cyc = 0, n_icv = 0, n_dcv = 0;
  int vlog [$];

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [LW-1:0] mem_read(input logic [AW-1:0] a);
    if (!mem_arr.exists(a)) mem_arr[a] = rand_line();
    return mem_arr[a];
  endfunction

  function automatic bit exp_busy(input int x);
    return m_act && (x >= m_gs + 1) && (x <= m_gs + L);
  endfunction

  function automatic bit exp_ic_v(input int x);
    return m_act && !m_own_dc && (x == m_gs + L + 1);
  endfunction

  function automatic bit exp_dc_v(input int x);
    return m_act && m_own_dc && (x == m_gs + L + 1);
  endfunction

  task automatic model_reset();
    m_act = 1'b0;
    m_last_dc = 1'b1;
    m_ic_rd = '0;
    m_dc_rd = '0;
    ic_q.delete();
    dc_q.delete();
    ic_req = 1'b0;
    dc_req = 1'b0;
  endtask

  task automatic clear_counts();
    n_req_cyc = 0; n_we_cyc = 0; n_icv = 0; n_dcv = 0;
    vlog.delete();
  endtask

  // One clock cycle: model the edge, drive cycle-c inputs, then compare cycle-c outputs.
  task automatic tick();
    bit ei, ed, pick_dc;
    @(posedge clk);
    ic_done = exp_ic_v(c);
    dc_done = exp_dc_v(c);
    if (rst) begin
      if (m_act && m_we && c == m_gs + L) mem_arr[m_addr] = m_wdata;
      if (!exp_busy(c)) begin
        ei = ic_req && !ic_done;
        ed = dc_req && !dc_done;
        if (ei || ed) begin
          pick_dc   = ed && (!ei || !m_last_dc);
          m_act     = 1'b1;
          m_gs      = c;
          m_own_dc  = pick_dc;
          m_last_dc = pick_dc;
          m_addr    = pick_dc ? dc_addr : ic_addr;
          m_we      = pick_dc ? dc_we : 1'b0;
          m_wdata   = pick_dc ? dc_wdata : '0;
        end
      end
    end
    c++;
    if (exp_ic_v(c) && !m_we) m_ic_rd = m_cap;
    if (exp_dc_v(c) && !m_we) m_dc_rd = m_cap;
    #1;
    mem_rdata = rand_line();
    if (exp_busy(c) && c == m_gs + L && !m_we) begin
      mem_rdata = mem_read(m_addr);
      m_cap = mem_rdata;
    end
    if (ic_done && ic_q.size() > 0) begin ic_q.delete(0); ic_req = 1'b0; end
    if (dc_done && dc_q.size() > 0) begin dc_q.delete(0); dc_req = 1'b0; end
    if (rst && !ic_req && ic_q.size() > 0 && (!rand_raise || $urandom_range(0, 2) != 0)) begin
      ic_req = 1'b1;
      ic_addr = ic_q[0];
    end
    if (rst && !dc_req && dc_q.size() > 0 && (!rand_raise || $urandom_range(0, 2) != 0)) begin
      dc_req = 1'b1;
      dc_we = dc_q[0].we;
      dc_addr = dc_q[0].addr;
      dc_wdata = dc_q[0].wdata;
    end
    @(negedge clk);
    check($sformatf("busy@%0d", c), LW'(busy), LW'(exp_busy(c)));
    check($sformatf("mem_req@%0d", c), LW'(mem_req), LW'(exp_busy(c)));
    check($sformatf("mem_we@%0d", c), LW'(mem_we), LW'(exp_busy(c) && m_we));
    check($sformatf("mem_addr@%0d", c), LW'(mem_addr), exp_busy(c) ? LW'(m_addr) : '0);
    check($sformatf("mem_wdata@%0d", c), mem_wdata, exp_busy(c) ? m_wdata : '0);
    check($sformatf("ic_valid@%0d", c), LW'(ic_valid), LW'(exp_ic_v(c)));
    check($sformatf("dc_valid@%0d", c), LW'(dc_valid), LW'(exp_dc_v(c)));
    check($sformatf("ic_rdata@%0d", c), ic_rdata, m_ic_rd);
    check($sformatf("dc_rdata@%0d", c), dc_rdata, m_dc_rd);
    if (mem_req) n_req_cyc++;
    if (mem_we) n_we_cyc++;
    if (ic_valid) begin ic_vcyc = c; n_icv++; vlog.push_back(0); end
    if (dc_valid) begin dc_vcyc = c; n_dcv++; vlog.push_back(1); end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((ic_q.size() > 0 || dc_q.size() > 0 || ic_req || dc_req || exp_busy(c)) && n < budget);
    check("run_budget", LW'(n < budget), LW'(1));
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int t0, n;
    logic [LW-1:0] v1, v3;

    // Power-on reset
    model_reset();
    tick();
    tick();
    tick();
    rst = 1'b1;

    // Single IC read
    mem_arr[32'h2000] = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
    clear_counts();
    t0 = c + 1;
    ic_q.push_back(32'h2000);
    run_until_idle(40);
    check("t1_ic_latency", LW'(ic_vcyc - t0), LW'(L + 1));
    check("t1_mem_req_cycles", LW'(n_req_cyc), LW'(L));
    check("t1_ic_pulses", LW'(n_icv), LW'(1));
    check("t1_dc_pulses", LW'(n_dcv), LW'(0));
    check("t1_ic_rdata", ic_rdata, 128'hDEADBEEF_01234567_89ABCDEF_00000001);

    // DC writeback, then a fill of the same line
    clear_counts();
    t0 = c + 1;
    dc_q.push_back('{we: 1'b1, addr: 32'h3010, wdata: {4{32'hAAAAAAAA}}});
    run_until_idle(40);
    check("t2_dc_latency", LW'(dc_vcyc - t0), LW'(L + 1));
    check("t2_mem_we_cycles", LW'(n_we_cyc), LW'(L));
    check("t2_dc_pulses", LW'(n_dcv), LW'(1));
    check("t2_dc_rdata_kept", dc_rdata, '0);
    dc_q.push_back('{we: 1'b0, addr: 32'h3010, wdata: '0});
    run_until_idle(40);
    check("t2_dc_readback", dc_rdata, {4{32'hAAAAAAAA}});

    // Simultaneous requests right after reset: IC first
    reset_dut();
    clear_counts();
    t0 = c + 1;
    ic_q.push_back(32'h2040);
    dc_q.push_back('{we: 1'b0, addr: 32'h3040, wdata: '0});
    run_until_idle(60);
    check("t3_ic_latency", LW'(ic_vcyc - t0), LW'(L + 1));
    check("t3_dc_latency", LW'(dc_vcyc - t0), LW'(2 * L + 2));

    // Continuous requests: grants alternate IC, DC, IC, DC
    clear_counts();
    ic_q.push_back(32'h2080); ic_q.push_back(32'h2090);
    dc_q.push_back('{we: 1'b1, addr: 32'h3080, wdata: rand_line()});
    dc_q.push_back('{we: 1'b0, addr: 32'h3080, wdata: '0});
    run_until_idle(80);
    check("t4_count", LW'(vlog.size()), LW'(4));
    for (int i = 0; i < 4 && i < vlog.size(); i++)
      check($sformatf("t4_order%0d", i), LW'(vlog[i]), LW'(i % 2));

    // After an IC grant, simultaneous requests go to DC first
    ic_q.push_back(32'h20A0);
    run_until_idle(40);
    clear_counts();
    ic_q.push_back(32'h20B0);
    dc_q.push_back('{we: 1'b0, addr: 32'h30B0, wdata: '0});
    run_until_idle(60);
    check("t4b_count", LW'(vlog.size()), LW'(2));
    if (vlog.size() == 2) begin
      check("t4b_first", LW'(vlog[0]), LW'(1));
      check("t4b_second", LW'(vlog[1]), LW'(0));
    end

    // Reset in the third BUSY cycle drops the transaction
    clear_counts();
    ic_q.push_back(32'h2100);
    n = 0;
    while (!(exp_busy(c) && c == m_gs + 3) && n < 50) begin tick(); n++; end
    check("t5_reach_busy", LW'(n < 50), LW'(1));
    #2 rst = 1'b0;
    #1;
    check("t5_rst_mem_req", LW'(mem_req), '0);
    check("t5_rst_busy", LW'(busy), '0);
    check("t5_rst_mem_we", LW'(mem_we), '0);
    check("t5_rst_mem_addr", LW'(mem_addr), '0);
    check("t5_rst_mem_wdata", mem_wdata, '0);
    check("t5_rst_ic_valid", LW'(ic_valid), '0);
    check("t5_rst_dc_valid", LW'(dc_valid), '0);
    check("t5_rst_ic_rdata", ic_rdata, '0);
    check("t5_rst_dc_rdata", dc_rdata, '0);
    model_reset();
    tick();
    tick();
    tick();
    rst = 1'b1;
    check("t5_no_pulse", LW'(n_icv), LW'(0));
    t0 = c + 1;
    ic_q.push_back(32'h2100);
    run_until_idle(40);
    check("t5_reissue_latency", LW'(ic_vcyc - t0), LW'(L + 1));

    // Randomized traffic over a small set of lines
    rand_raise = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (ic_q.size() < 2 && $urandom_range(0, 3) == 0)
        ic_q.push_back(32'h1000 + 32'($urandom_range(0, 7)) * 32'h10);
      if (dc_q.size() < 2 && $urandom_range(0, 3) == 0)
        dc_q.push_back('{we: 1'($urandom_range(0, 1)),
                         addr: 32'h1000 + 32'($urandom_range(0, 7)) * 32'h10,
                         wdata: rand_line()});
      tick();
    end
    run_until_idle(200);
    rand_raise = 1'b0;

    // MEM_LATENCY=1 instance: IC then DC back-to-back
    @(posedge clk); #1;
    s_ic_req = 1'b1; s_ic_addr = 32'h40;
    s_dc_req = 1'b1; s_dc_we = 1'b0; s_dc_addr = 32'h80;
    s_mem_rdata = rand_line();
    @(negedge clk);
    check("l1_c0_mem_req", LW'(s_mem_req), '0);
    @(posedge clk); #1;
    v1 = rand_line();
    s_mem_rdata = v1;
    @(negedge clk);
    check("l1_c1_mem_req", LW'(s_mem_req), LW'(1));
    check("l1_c1_mem_addr", LW'(s_mem_addr), LW'(32'h40));
    check("l1_c1_busy", LW'(s_busy), LW'(1));
    check("l1_c1_ic_valid", LW'(s_ic_valid), '0);
    @(posedge clk); #1;
    s_mem_rdata = rand_line();
    @(negedge clk);
    check("l1_c2_ic_valid", LW'(s_ic_valid), LW'(1));
    check("l1_c2_ic_rdata", s_ic_rdata, v1);
    check("l1_c2_mem_req", LW'(s_mem_req), '0);
    check("l1_c2_dc_valid", LW'(s_dc_valid), '0);
    @(posedge clk); #1;
    s_ic_req = 1'b0;
    v3 = rand_line();
    s_mem_rdata = v3;
    @(negedge clk);
    check("l1_c3_mem_req", LW'(s_mem_req), LW'(1));
    check("l1_c3_mem_addr", LW'(s_mem_addr), LW'(32'h80));
    check("l1_c3_ic_valid", LW'(s_ic_valid), '0);
    @(posedge clk); #1;
    s_mem_rdata = rand_line();
    @(negedge clk);
    check("l1_c4_dc_valid", LW'(s_dc_valid), LW'(1));
    check("l1_c4_dc_rdata", s_dc_rdata, v3);
    check("l1_c4_mem_req", LW'(s_mem_req), '0);
    check("l1_c4_ic_rdata", s_ic_rdata, v1);
    @(posedge clk); #1;
    s_dc_req = 1'b0;
    @(negedge clk);
    check("l1_c5_dc_valid", LW'(s_dc_valid), '0);
    check("l1_c5_busy", LW'(s_busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
